rl_force_collector: RTL and testbench
=====================================

Name: rl_force_collector

Overview:
- Receiving end of the range-limited pipeline output interface.
- Takes `forceoutput` / `forceoutput_valid` / `done` from NUM_PIPELINES parallel RL pipelines and buffers each lane in a small FIFO.
- Round-robin arbitrates the lanes into one valid/ready force stream, with a lane tag, for the downstream force accumulation / writeback logic.
- Signals completion once every pipeline is done and all buffered forces have been delivered.

Parameters:
- DATA_WIDTH, 32, width of one force value.
- NUM_PIPELINES, 8, number of RL pipeline lanes collected.
- LANE_ID_WIDTH, 3, clog2(NUM_PIPELINES); minimum 1.
- FIFO_DEPTH, 4, entries per lane FIFO; power of two, at least 2.
- COUNT_WIDTH, 16, width of the delivered-force counter.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a collection run.
- in_force  in  NUM_PIPELINES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_PIPELINES  per-lane forceoutput_valid; there is no backpressure to the pipelines.
- in_done  in  NUM_PIPELINES  per-lane done level.
- out_force  out  DATA_WIDTH  arbitrated force value.
- out_lane_id  out  LANE_ID_WIDTH  lane that produced out_force.
- out_valid  out  1  out_force / out_lane_id are valid.
- out_ready  in  1  downstream accepts the current output.
- force_count  out  COUNT_WIDTH  number of handshakes completed this run.
- overflow  out  1  sticky: a lane sample was dropped because its FIFO was full.
- done  out  1  run complete; held high until the next start.

Behaviour:
- Reset: state=IDLE, all FIFOs empty, rr pointer=0, done-latches=0.
  - Outputs: out_valid=0, out_force=0, out_lane_id=0, force_count=0, overflow=0, done=0.
  - Reset mid-run discards all buffered data.
- State machine IDLE / COLLECT / DRAIN / DONE:
  - IDLE: in_valid and in_done are ignored. start -> COLLECT.
  - COLLECT: per-lane in_valid pushes into that lane's FIFO. in_done[i]=1 sets sticky done_latch[i]. When all latches are set (including bits set this cycle) -> DRAIN.
  - DRAIN: pushes are still accepted (late samples are not lost). When all FIFOs are empty and out_valid=0 -> DONE.
  - DONE: done=1. start -> COLLECT.
- Every entry into COLLECT clears force_count, overflow and done_latch. FIFO contents are empty by construction at that point.
- start while in COLLECT or DRAIN is ignored.
- Push on a full FIFO:
  - If the same lane is popped that cycle, the push succeeds.
  - Otherwise the sample is dropped and overflow is set until the next start or rst.
- Output register:
  - Loaded when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
  - Loaded from the first non-empty lane, searching upward from the rr pointer with wrap-around.
  - After a grant to lane k, rr pointer = k+1, wrapping NUM_PIPELINES-1 -> 0.
  - Back-to-back handshakes therefore sustain 1 force per cycle.
  - While out_valid=1 and out_ready=0, out_force and out_lane_id are held stable.
- Latency: in_valid in cycle t, with empty FIFOs and an idle output, gives out_valid=1 in cycle t+2.
- force_count increments on each out_valid&&out_ready and wraps modulo 2^COUNT_WIDTH.
- Within a lane, samples are delivered in arrival order. Across lanes, the order is arbitration order.

Decomposition:
- Package rl_collector_pkg:
  - state enum: IDLE, COLLECT, DRAIN, DONE;
  - lane-id width helper (clog2);
  - default widths.
- Sub-module rl_force_lane_fifo, instantiated per lane:
  - DATA_WIDTH x FIFO_DEPTH, synchronous;
  - push, pop, full and empty flags;
  - simultaneous push+pop when full is allowed.
- Arbiter and FSM stay in the top module.

Test Plan:
1. All 8 lanes pulse in_valid in one cycle with force = 0x100+i, out_ready=1.
   - Outputs on 8 consecutive cycles: lane ids 0..7, forces 0x100..0x107.
   - force_count=8.
2. Lane 3 only: 5 samples on consecutive cycles, out_ready=0.
   - 4 are buffered and overflow=1.
   - After releasing out_ready, exactly 4 outputs appear, in order.
3. Hold out_ready=0 for 3 cycles with out_valid=1.
   - out_force and out_lane_id remain unchanged.
   - Release: handshake occurs, then the next lane in round-robin order is presented.
4. in_done asserted lane-by-lane over 8 cycles while 2 samples are still buffered.
   - done rises only after both samples handshake: DRAIN, then DONE.
   - done stays high until start.
5. rst asserted in DRAIN with 3 samples buffered.
   - Next cycle: out_valid=0, force_count=0, done=0, state IDLE.
   - in_valid is then ignored until start.
6. Second start from DONE.
   - force_count, overflow and done clear.
   - A new sample from lane 7 is output with lane id 7 two cycles later.

Source files
------------

// File: rtl/rl_collector_pkg.sv
// rl_collector_pkg: shared state encoding, width helper and default sizes for the RL force collector
package rl_collector_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_PIPELINES = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_COUNT_WIDTH = 16;
  function automatic int lane_id_width(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rl_force_lane_fifo.sv
// rl_force_lane_fifo: per-lane synchronous FIFO, push accepted when full if popped in the same cycle
module rl_force_lane_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/rl_force_collector.sv
// rl_force_collector: buffers RL pipeline force outputs per lane and round-robins them into one tagged stream
module rl_force_collector
  import rl_collector_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_PIPELINES = DEF_NUM_PIPELINES,
  parameter int LANE_ID_WIDTH = lane_id_width(NUM_PIPELINES),
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [NUM_PIPELINES*DATA_WIDTH-1:0] in_force,
  input  logic [NUM_PIPELINES-1:0]           in_valid,
  input  logic [NUM_PIPELINES-1:0]           in_done,
  output logic [DATA_WIDTH-1:0]              out_force,
  output logic [LANE_ID_WIDTH-1:0]           out_lane_id,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [COUNT_WIDTH-1:0]             force_count,
  output logic                               overflow,
  output logic                               done
);
  state_t state, state_nx;
  logic [NUM_PIPELINES-1:0] done_latch, empty, full, push, pop;
  logic [DATA_WIDTH-1:0] lane_data [NUM_PIPELINES];
  logic [LANE_ID_WIDTH-1:0] rr, grant_id;
  logic any, grant, load, enter, active, drop;
  int idx;
  assign active = state == COLLECT || state == DRAIN;
  assign enter = start && (state == IDLE || state == DONE);
  assign load = !out_valid || out_ready;
  assign push = active ? in_valid : '0;
  assign grant = load && any;
  assign pop = grant ? NUM_PIPELINES'(1) << grant_id : '0;
  assign drop = |(push & full & ~pop);
  assign done = state == DONE;
  genvar i;
  generate
    for (i = 0; i < NUM_PIPELINES; i++) begin : g_lane
      rl_force_lane_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push[i]),
        .pop(pop[i]),
        .wr_data(in_force[i*DATA_WIDTH +: DATA_WIDTH]),
        .rd_data(lane_data[i]),
        .full(full[i]),
        .empty(empty[i])
      );
    end
  endgenerate
  // Scan offsets high to low so the nearest non-empty lane after rr wins last.
  always_comb begin
    any = 1'b0;
    grant_id = '0;
    idx = 0;
    for (int k = NUM_PIPELINES - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % NUM_PIPELINES;
      if (!empty[idx]) begin
        any = 1'b1;
        grant_id = LANE_ID_WIDTH'(idx);
      end
    end
  end
  always_comb begin
    state_nx = enter ? COLLECT
             : state == COLLECT && &(done_latch | in_done) ? DRAIN
             : state == DRAIN && &empty && !out_valid ? DONE
             : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done_latch <= '0;
      rr <= '0;
      out_valid <= 1'b0;
      out_force <= '0;
      out_lane_id <= '0;
      force_count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        out_valid <= 1'b1;
        out_force <= lane_data[grant_id];
        out_lane_id <= grant_id;
        rr <= grant_id == LANE_ID_WIDTH'(NUM_PIPELINES - 1) ? '0 : grant_id + LANE_ID_WIDTH'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (enter) begin
        force_count <= '0;
        overflow <= 1'b0;
        done_latch <= '0;
      end else begin
        if (out_valid && out_ready) force_count <= force_count + COUNT_WIDTH'(1);
        if (drop) overflow <= 1'b1;
        if (state == COLLECT) done_latch <= done_latch | in_done;
      end
    end
  end
endmodule

// File: tb/tb_rl_force_collector.sv
// tb_rl_force_collector: scoreboard plus vector-table bench for the RL force collector
module tb_rl_force_collector;
  localparam int DW = 32;
  localparam int NP = 8;
  logic clk = 1'b0;
  logic rst, start, out_ready, out_valid, overflow, done;
  logic [NP*DW-1:0] in_force;
  logic [NP-1:0] in_valid, in_done;
  logic [DW-1:0] out_force;
  logic [2:0] out_lane_id;
  logic [15:0] force_count;
  typedef struct {
    logic [2:0] lane;
    logic [31:0] frc;
  } exp_t;
  typedef struct {
    int lane;
    logic [31:0] frc;
    int cnt;
  } vec_t;
  exp_t exp_q[$];
  vec_t vecs[4];
  int checks = 0;
  int errors = 0;
  rl_force_collector dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_force(in_force),
    .in_valid(in_valid),
    .in_done(in_done),
    .out_force(out_force),
    .out_lane_id(out_lane_id),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .force_count(force_count),
    .overflow(overflow),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic put(input int lane, input logic [31:0] f, input bit sb);
    exp_t e;
    in_force[lane*DW +: DW] = f;
    in_valid[lane] = 1'b1;
    e.lane = 3'(lane);
    e.frc = f;
    if (sb) exp_q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got lane %0d force %0h, expected nothing", out_lane_id, out_force);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_lane_id !== e.lane || out_force !== e.frc) begin
          errors++;
          $display("FAIL sb_order: got lane %0d force %0h expected lane %0d force %0h", out_lane_id, out_force, e.lane, e.frc);
        end
      end
    end
  end
  initial begin
    vecs[0] = '{7, 32'h0000_0777, 0};
    vecs[1] = '{2, 32'h0000_0222, 1};
    vecs[2] = '{0, 32'h0000_0a00, 2};
    vecs[3] = '{4, 32'h0000_0444, 3};
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    in_force = '0; in_valid = '0; in_done = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_force", 64'(out_force), 0);
    check("rst_out_lane", 64'(out_lane_id), 0);
    check("rst_count", 64'(force_count), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_done", 64'(done), 0);
    // all lanes in one cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int l = 0; l < NP; l++) put(l, 32'h100 + 32'(l), 1);
    tick();
    in_valid = '0;
    check("t1_latency_gap", 64'(out_valid), 0);
    tick();
    for (int k = 0; k < NP; k++) begin
      check("t1_valid", 64'(out_valid), 1);
      check("t1_lane", 64'(out_lane_id), 64'(k));
      tick();
    end
    check("t1_count", 64'(force_count), 8);
    check("t1_idle", 64'(out_valid), 0);
    // overflow on lane 3 behind a stalled output
    out_ready = 1'b0;
    put(0, 32'h200, 1);
    tick();
    in_valid = '0;
    tick();
    for (int j = 0; j < 5; j++) begin
      put(3, 32'h300 + 32'(j), j < 4);
      tick();
    end
    in_valid = '0;
    check("t2_overflow", 64'(overflow), 1);
    for (int j = 0; j < 3; j++) begin
      check("t3_hold_valid", 64'(out_valid), 1);
      check("t3_hold_lane", 64'(out_lane_id), 0);
      check("t3_hold_force", 64'(out_force), 64'h200);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t3_rr_lane", 64'(out_lane_id), 3);
    check("t3_rr_force", 64'(out_force), 64'h300);
    repeat (5) tick();
    check("t2_count", 64'(force_count), 13);
    check("t2_drained", 64'(exp_q.size()), 0);
    // done after drain
    out_ready = 1'b0;
    put(5, 32'h500, 1);
    put(6, 32'h600, 1);
    tick();
    in_valid = '0;
    for (int j = 0; j < NP; j++) begin
      in_done = NP'(1) << j;
      tick();
    end
    in_done = '0;
    for (int j = 0; j < 3; j++) begin
      check("t4_done_wait", 64'(done), 0);
      tick();
    end
    out_ready = 1'b1;
    check("t4_done_r0", 64'(done), 0);
    tick();
    check("t4_done_r1", 64'(done), 0);
    tick();
    check("t4_done_r2", 64'(done), 0);
    tick();
    check("t4_done_r3", 64'(done), 1);
    check("t4_count", 64'(force_count), 15);
    repeat (3) tick();
    check("t4_done_hold", 64'(done), 1);
    // restart from DONE, then single-sample vectors
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_count_clr", 64'(force_count), 0);
    check("t6_ovf_clr", 64'(overflow), 0);
    check("t6_done_clr", 64'(done), 0);
    for (int v = 0; v < 4; v++) begin
      put(vecs[v].lane, vecs[v].frc, 1);
      tick();
      in_valid = '0;
      check("vec_gap", 64'(out_valid), 0);
      tick();
      check("vec_valid", 64'(out_valid), 1);
      check("vec_lane", 64'(out_lane_id), 64'(vecs[v].lane));
      check("vec_force", 64'(out_force), 64'(vecs[v].frc));
      check("vec_count", 64'(force_count), 64'(vecs[v].cnt));
      tick();
    end
    // reset in DRAIN discards buffered data
    out_ready = 1'b0;
    put(1, 32'h111, 0);
    put(2, 32'h122, 0);
    put(3, 32'h133, 0);
    tick();
    in_valid = '0;
    in_done = '1;
    tick();
    in_done = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t5_valid", 64'(out_valid), 0);
    check("t5_count", 64'(force_count), 0);
    check("t5_done", 64'(done), 0);
    out_ready = 1'b1;
    put(4, 32'h444, 0);
    tick();
    in_valid = '0;
    for (int j = 0; j < 4; j++) begin
      check("t5_ignored", 64'(out_valid), 0);
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    put(2, 32'h777, 1);
    tick();
    in_valid = '0;
    tick();
    check("t5_new_valid", 64'(out_valid), 1);
    check("t5_new_lane", 64'(out_lane_id), 2);
    check("t5_new_force", 64'(out_force), 64'h777);
    repeat (2) tick();
    check("t5_sb_empty", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
